// File: rtl/layer_fetch_pkg.sv
// Shared types and constants for the sprite layer fetch scheduler.
// The optional LAYER_FETCH_EARLY_OUT_EN build is handled in layer_fetch_sched.
package layer_fetch_pkg;

    localparam int          DEFAULT_NUM_LAYERS = 8;
    localparam logic [15:0] TRANSPARENT        = 16'h7C1F;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        PUBLISH
    } state_t;

endpackage

// File: rtl/prio_pick.sv
// Lowest-set-bit encoder: index of the highest-priority requester plus a found flag.
module prio_pick #(
    parameter int  N  = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          found
);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Scanning downwards lets the lowest set bit overwrite any higher one.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_fetch_sched.sv
// Per-pixel sprite layer fetch scheduler: one memory read per requested layer, then publish.
// Build option: define LAYER_FETCH_EARLY_OUT_EN to stop fetching behind the first opaque layer.
module layer_fetch_sched
    import layer_fetch_pkg::*;
#(
    parameter int NUM_LAYERS = DEFAULT_NUM_LAYERS,
    parameter int ADDR_W     = 19
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pixel_start,
    input  logic [NUM_LAYERS-1:0]        layer_req,
    input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
    output logic                         mem_rd,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic [15:0]                  mem_rdata,
    output logic [NUM_LAYERS*16-1:0]     layer_color,
    output logic                         colors_valid,
    output logic                         busy,
    output logic                         overrun,
    input  logic                         overrun_clr
);

    localparam int IW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    state_t                       state;
    logic [NUM_LAYERS-1:0]        pending;
    logic [NUM_LAYERS*ADDR_W-1:0] addr_q;
    logic [IW-1:0]                issue_idx;
    logic                         land_valid;
    logic [IW-1:0]                land_idx;
    logic [NUM_LAYERS*16-1:0]     staging;
    logic [NUM_LAYERS*16-1:0]     staging_next;

    logic                         start;
    logic                         land_keep;
    logic                         kill;
    logic [NUM_LAYERS-1:0]        pending_eff;
    logic [NUM_LAYERS-1:0]        pick_src;
    logic [NUM_LAYERS-1:0]        rest_mask;
    logic [NUM_LAYERS*ADDR_W-1:0] addr_src;
    logic [IW-1:0]                pick_idx;
    logic                         pick_found;
    logic [ADDR_W-1:0]            pick_addr;
    logic                         issue_now;

    assign start = pixel_start && (state == IDLE);
    assign busy  = (state != IDLE);

`ifdef LAYER_FETCH_EARLY_OUT_EN
    logic opaque_seen;

    // Once an opaque word has landed, every later landing belongs to a lower-priority layer.
    assign land_keep = land_valid && !opaque_seen;
    assign kill      = land_keep && (mem_rdata[14:0] != TRANSPARENT[14:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        opaque_seen <= 1'b0;
        else if (start) opaque_seen <= 1'b0;
        else if (kill)  opaque_seen <= 1'b1;
    end
`else
    assign land_keep = land_valid;
    assign kill      = 1'b0;
`endif

    // Issue order is ascending, so everything still pending sits behind the landing layer.
    assign pending_eff = (pixel_start || kill) ? '0 : pending;
    assign pick_src    = start ? layer_req : pending_eff;
    assign rest_mask   = pick_src & (pick_src - NUM_LAYERS'(1));
    assign addr_src    = start ? layer_addr : addr_q;
    assign pick_addr   = addr_src[int'(pick_idx)*ADDR_W +: ADDR_W];
    assign issue_now   = pick_found && (start || (state == ISSUE));

    prio_pick #(.N(NUM_LAYERS)) u_pick (
        .req   (pick_src),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        staging_next = staging;
        if (land_keep) staging_next[int'(land_idx)*16 +: 16] = mem_rdata;
    end

    // NOTE: the address capture has no reset; it is only read after a slot start reloads it.
    always_ff @(posedge clk) begin
        if (start) addr_q <= layer_addr;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pending      <= '0;
            mem_rd       <= 1'b0;
            mem_addr     <= '0;
            issue_idx    <= '0;
            land_valid   <= 1'b0;
            land_idx     <= '0;
            staging      <= {NUM_LAYERS{TRANSPARENT}};
            layer_color  <= {NUM_LAYERS{TRANSPARENT}};
            colors_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            pending    <= rest_mask;
            mem_rd     <= issue_now;
            if (issue_now) begin
                mem_addr  <= pick_addr;
                issue_idx <= pick_idx;
            end
            land_valid <= mem_rd;
            land_idx   <= issue_idx;

            staging      <= start ? {NUM_LAYERS{TRANSPARENT}} : staging_next;
            colors_valid <= (state == DRAIN);
            if (state == DRAIN) layer_color <= staging_next;

            // A new overrun wins over a simultaneous clear.
            if (pixel_start && (state != IDLE)) overrun <= 1'b1;
            else if (overrun_clr)               overrun <= 1'b0;

            case (state)
                IDLE:    if (pixel_start) state <= issue_now ? ISSUE : DRAIN;
                ISSUE:   state <= issue_now ? ISSUE : DRAIN;
                DRAIN:   state <= PUBLISH;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_fetch_sched.sv
// Directed bench for layer_fetch_sched; the early-out scenario runs only when
// LAYER_FETCH_EARLY_OUT_EN is defined, the multi-layer default scenarios only when it is not.
module tb_layer_fetch_sched;
    import layer_fetch_pkg::*;

    localparam int NL = 8;
    localparam int AW = 19;

    logic             clk = 1'b0;
    logic             rst;
    logic             pixel_start;
    logic [NL-1:0]    layer_req;
    logic [NL*AW-1:0] layer_addr;
    logic             mem_rd;
    logic [AW-1:0]    mem_addr;
    logic [15:0]      mem_rdata;
    logic [NL*16-1:0] layer_color;
    logic             colors_valid;
    logic             busy;
    logic             overrun;
    logic             overrun_clr;

    layer_fetch_sched #(.NUM_LAYERS(NL), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .pixel_start  (pixel_start),
        .layer_req    (layer_req),
        .layer_addr   (layer_addr),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .layer_color  (layer_color),
        .colors_valid (colors_valid),
        .busy         (busy),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] iss_addr[$];
    int            iss_cyc[$];
    int            cv_cyc[$];

    always @(negedge clk) begin
        if (mem_rd) begin
            iss_addr.push_back(mem_addr);
            iss_cyc.push_back(cyc);
        end
        if (colors_valid) cv_cyc.push_back(cyc);
    end

    function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
        case (a)
            19'h00123: return 16'h03E0;
            19'h00600: return 16'h001F;
            default:   return {1'b0, a[14:0]};
        endcase
    endfunction

    // Sprite memory: one-cycle read latency, garbage when not reading.
    always @(posedge clk) mem_rdata <= mem_rd ? mem_word(mem_addr) : 16'hDEAD;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_colors(input string tag, input logic [NL*16-1:0] exp);
        for (int i = 0; i < NL; i++)
            check($sformatf("%s_l%0d", tag, i), 64'(layer_color[i*16 +: 16]), 64'(exp[i*16 +: 16]));
    endtask

    function automatic logic [NL*AW-1:0] addrs_from(input logic [AW-1:0] base);
        logic [NL*AW-1:0] v;
        for (int i = 0; i < NL; i++) v[i*AW +: AW] = base + AW'(i);
        return v;
    endfunction

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic [AW-1:0] a_at(input logic [AW-1:0] q[$], input int i);
        return (i < q.size()) ? q[i] : '1;
    endfunction

    task automatic start_slot(input logic [NL-1:0] req, input logic [AW-1:0] base, output int t);
        iss_addr.delete();
        iss_cyc.delete();
        cv_cyc.delete();
        @(posedge clk); #1;
        pixel_start = 1'b1;
        layer_req   = req;
        layer_addr  = addrs_from(base);
        t           = cyc;
        @(posedge clk); #1;
        pixel_start = 1'b0;
        layer_req   = '0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int               t;
        logic [NL*16-1:0] exp;

        rst         = 1'b1;
        pixel_start = 1'b0;
        layer_req   = '0;
        layer_addr  = '0;
        overrun_clr = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_rd", 64'(mem_rd), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_colors_valid", 64'(colors_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_overrun", 64'(overrun), 64'(0));
        check_colors("rst_color", {NL{16'h7C1F}});
        @(posedge clk); #1;
        rst = 1'b0;

        // Single layer
        start_slot(8'b0000_0100, 19'h00121, t);
        check("s1_busy", 64'(busy), 64'(1));
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("s1_issue_cnt", 64'(iss_addr.size()), 64'(1));
        check("s1_issue_addr", 64'(a_at(iss_addr, 0)), 64'(19'h00123));
        check("s1_issue_cyc", 64'(q_at(iss_cyc, 0)), 64'(t + 1));
        check("s1_cv_cnt", 64'(cv_cyc.size()), 64'(1));
        check("s1_cv_cyc", 64'(q_at(cv_cyc, 0)), 64'(t + 3));
        exp = {NL{16'h7C1F}};
        exp[2*16 +: 16] = 16'h03E0;
        check_colors("s1_color", exp);
        check("s1_addr_hold", 64'(mem_addr), 64'(19'h00123));
        check("s1_idle", 64'(busy), 64'(0));

        // Empty request
        start_slot(8'h00, 19'h00700, t);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("s0_issue_cnt", 64'(iss_addr.size()), 64'(0));
        check("s0_cv_cnt", 64'(cv_cyc.size()), 64'(1));
        check("s0_cv_cyc", 64'(q_at(cv_cyc, 0)), 64'(t + 2));
        check_colors("s0_color", {NL{16'h7C1F}});

`ifndef LAYER_FETCH_EARLY_OUT_EN
        // Three layers, issued in priority order
        start_slot(8'b1000_0011, 19'h00200, t);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("s3_issue_cnt", 64'(iss_addr.size()), 64'(3));
        check("s3_issue0_addr", 64'(a_at(iss_addr, 0)), 64'(19'h00200));
        check("s3_issue1_addr", 64'(a_at(iss_addr, 1)), 64'(19'h00201));
        check("s3_issue2_addr", 64'(a_at(iss_addr, 2)), 64'(19'h00207));
        check("s3_issue0_cyc", 64'(q_at(iss_cyc, 0)), 64'(t + 1));
        check("s3_issue2_cyc", 64'(q_at(iss_cyc, 2)), 64'(t + 3));
        check("s3_cv_cyc", 64'(q_at(cv_cyc, 0)), 64'(t + 5));
        exp = {NL{16'h7C1F}};
        exp[0*16 +: 16] = 16'h0200;
        exp[1*16 +: 16] = 16'h0201;
        exp[7*16 +: 16] = 16'h0207;
        check_colors("s3_color", exp);

        // Overrun: second pixel_start three cycles into a full slot
        start_slot(8'hFF, 19'h00300, t);
        @(posedge clk); #1;
        @(posedge clk); #1;
        pixel_start = 1'b1;
        layer_req   = 8'hFF;
        @(posedge clk); #1;
        pixel_start = 1'b0;
        layer_req   = '0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("ov_issue_cnt", 64'(iss_addr.size()), 64'(3));
        check("ov_issue2_addr", 64'(a_at(iss_addr, 2)), 64'(19'h00302));
        check("ov_cv_cnt", 64'(cv_cyc.size()), 64'(1));
        check("ov_cv_cyc", 64'(q_at(cv_cyc, 0)), 64'(t + 5));
        exp = {NL{16'h7C1F}};
        exp[0*16 +: 16] = 16'h0300;
        exp[1*16 +: 16] = 16'h0301;
        exp[2*16 +: 16] = 16'h0302;
        check_colors("ov_color", exp);
        check("ov_sticky", 64'(overrun), 64'(1));
        @(posedge clk); #1;
        overrun_clr = 1'b1;
        @(posedge clk); #1;
        overrun_clr = 1'b0;
        @(negedge clk);
        check("ov_cleared", 64'(overrun), 64'(0));
`else
        // Early out: layer 0 is opaque, layer 1 read completes but is dropped
        start_slot(8'hFF, 19'h00600, t);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("eo_issue_cnt", 64'(iss_addr.size()), 64'(2));
        check("eo_issue1_addr", 64'(a_at(iss_addr, 1)), 64'(19'h00601));
        check("eo_cv_cyc", 64'(q_at(cv_cyc, 0)), 64'(t + 4));
        exp = {NL{16'h7C1F}};
        exp[0*16 +: 16] = 16'h001F;
        check_colors("eo_color", exp);
`endif

        // Reset two cycles into a four-layer slot
        start_slot(8'h0F, 19'h00400, t);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mr_mem_rd", 64'(mem_rd), 64'(0));
        check("mr_mem_addr", 64'(mem_addr), 64'(0));
        check("mr_busy", 64'(busy), 64'(0));
        check("mr_colors_valid", 64'(colors_valid), 64'(0));
        check_colors("mr_color", {NL{16'h7C1F}});
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("mr_no_publish", 64'(cv_cyc.size()), 64'(0));

        // Service resumes normally after reset
        start_slot(8'b0001_0000, 19'h00500, t);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("pr_issue_cnt", 64'(iss_addr.size()), 64'(1));
        check("pr_issue_addr", 64'(a_at(iss_addr, 0)), 64'(19'h00504));
        check("pr_cv_cyc", 64'(q_at(cv_cyc, 0)), 64'(t + 3));
        exp = {NL{16'h7C1F}};
        exp[4*16 +: 16] = 16'h0504;
        check_colors("pr_color", exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
